// File: rtl/sysio_mtime_gen.sv
// sysio_mtime_gen
//   Produces the 64-bit machine timer value that feeds the CLINT. The count
//   advances by one on each tick. A tick comes from one of two sources:
//   - a synchronised, edge-detected external pulse, or
//   - an internal programmable divider.
//   The block also supports debug halt, loading the count, and a sticky wrap flag.
//
// Ports
//   forever_cpuclk     in   free-running clock (only clock)
//   cpurst_b           in   async active-low reset
//   pad_sysio_tick     in   async external tick, one increment per rising edge
//   tick_src_sel       in   0 = external tick, 1 = internal divider
//   div_ratio          in   internal tick period minus 1 (cycles)
//   cnt_halt           in   freeze count and divider
//   load_vld           in   one-cycle load request (beats any tick)
//   load_data          in   value to load
//   ovf_clr            in   clear sticky wrap flag
//   sysio_clint_mtime  out  registered timer value
//   sysio_tick_pulse   out  high the cycle a freshly incremented value appears
//   sysio_mtime_ovf    out  sticky: count wrapped all-ones -> 0
module sysio_mtime_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 8
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             pad_sysio_tick,
    input  logic             tick_src_sel,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             cnt_halt,
    input  logic             load_vld,
    input  logic [63:0]      load_data,
    input  logic             ovf_clr,
    output logic [63:0]      sysio_clint_mtime,
    output logic             sysio_tick_pulse,
    output logic             sysio_mtime_ovf
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   prev_q;
    logic                   sel_q;
    logic [DIV_W-1:0]       div_cnt;
    logic                   src_switch;
    logic                   ext_tick;
    logic                   int_tick;
    logic                   tick;

    assign sync_out   = sync_q[SYNC_STAGES-1];
    assign ext_tick   = sync_out & ~prev_q;
    // >= rather than == so that lowering div_ratio below the running count
    // ticks at once instead of waiting for the counter to wrap.
    assign int_tick   = (div_cnt >= div_ratio);
    // Suppress both sources in the cycle the select changes, so an external
    // level that is already high cannot look like a fresh edge.
    assign src_switch = (tick_src_sel != sel_q);
    assign tick       = (sel_q ? int_tick : ext_tick) & ~cnt_halt & ~src_switch;

    // Synchroniser, edge detect and source select register. prev_q always
    // follows sync_out, including during halt and source switches, so edges
    // seen while halted are dropped rather than queued.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            sel_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_sysio_tick};
            prev_q <= sync_out;
            sel_q  <= tick_src_sel;
        end
    end

    // Internal divider: runs only while selected and not halted.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            div_cnt <= '0;
        end else if (src_switch) begin
            div_cnt <= '0;
        end else if (sel_q && !cnt_halt) begin
            div_cnt <= int_tick ? '0 : div_cnt + 1'b1;
        end
    end

    // Timer value and tick pulse. A load takes the whole cycle: it discards a
    // coincident tick and leaves the wrap flag alone.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sysio_clint_mtime <= '0;
            sysio_tick_pulse  <= 1'b0;
        end else if (load_vld) begin
            sysio_clint_mtime <= load_data;
            sysio_tick_pulse  <= 1'b0;
        end else if (tick) begin
            sysio_clint_mtime <= sysio_clint_mtime + 64'd1;
            sysio_tick_pulse  <= 1'b1;
        end else begin
            sysio_tick_pulse  <= 1'b0;
        end
    end

    // Sticky wrap flag; a set in the same cycle as a clear wins.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sysio_mtime_ovf <= 1'b0;
        end else if (tick && !load_vld && (&sysio_clint_mtime)) begin
            sysio_mtime_ovf <= 1'b1;
        end else if (ovf_clr) begin
            sysio_mtime_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sysio_mtime_gen.sv
// Bench for sysio_mtime_gen. It applies a directed sequence followed by a
// randomized phase. Every cycle it compares the DUT against a behavioural
// model built from the pad sample history and a "cycles since last internal
// tick" count.
module tb_sysio_mtime_gen;
    localparam int S = 2;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pad = 1'b0;
    logic          sel = 1'b0;
    logic [W-1:0]  ratio = '0;
    logic          halt = 1'b0;
    logic          load = 1'b0;
    logic [63:0]   ldata = '0;
    logic          clr = 1'b0;
    logic [63:0]   mtime;
    logic          pulse;
    logic          ovf;

    int checks = 0;
    int failures = 0;

    sysio_mtime_gen #(.SYNC_STAGES(S), .DIV_W(W)) dut (
        .forever_cpuclk   (clk),
        .cpurst_b         (rst_n),
        .pad_sysio_tick   (pad),
        .tick_src_sel     (sel),
        .div_ratio        (ratio),
        .cnt_halt         (halt),
        .load_vld         (load),
        .load_data        (ldata),
        .ovf_clr          (clr),
        .sysio_clint_mtime(mtime),
        .sysio_tick_pulse (pulse),
        .sysio_mtime_ovf  (ovf)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [63:0] m_mtime;
    bit          m_pulse, m_ovf, m_sel;
    int          m_since;     // cycles elapsed in the current internal period
    bit          hist[$];     // pad samples, hist[0] = most recent edge

    task automatic model_reset();
        m_mtime = '0; m_pulse = 0; m_ovf = 0; m_sel = 0; m_since = 0;
        hist = {};
        for (int i = 0; i <= S; i++) hist.push_back(1'b0);
    endtask

    task automatic model_edge();
        bit ext, itk, sw, tk;
        if (!rst_n) begin model_reset(); return; end
        // A pad rise is seen S edges after it is sampled.
        ext = hist[S-1] && !hist[S];
        itk = (m_since >= int'(ratio));
        sw  = (sel != m_sel);
        tk  = (m_sel ? itk : ext) && !halt && !sw;
        if (sw) m_since = 0;
        else if (m_sel && !halt) m_since = itk ? 0 : m_since + 1;
        if (load) begin
            m_mtime = ldata; m_pulse = 0;
        end else if (tk) begin
            if (m_mtime == 64'hFFFF_FFFF_FFFF_FFFF) m_ovf = 1;
            m_mtime = m_mtime + 64'd1; m_pulse = 1;
        end else begin
            m_pulse = 0;
        end
        if (clr && !(tk && !load && m_mtime == 64'd0)) m_ovf = 0;
        m_sel = sel;
        hist.push_front(pad);
        void'(hist.pop_back());
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    int pcount = 0;

    // One clock: model at posedge, compare at negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("mtime", mtime, m_mtime);
        chk("pulse", {63'd0, pulse}, {63'd0, m_pulse});
        chk("ovf", {63'd0, ovf}, {63'd0, m_ovf});
        if (pulse === 1'b1) pcount++;
    endtask

    task automatic pad_pulse(input int hi, input int lo);
        pad = 1'b1; repeat (hi) step();
        pad = 1'b0; repeat (lo) step();
    endtask

    logic [63:0] saved;
    int          hold;
    bit          hit;

    initial begin
        model_reset();
        #1;
        chk("rst_mtime", mtime, 64'd0);
        chk("rst_pulse", {63'd0, pulse}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        repeat (2) step();
        rst_n = 1'b1;

        // External path: first pulse with explicit latency checks.
        pcount = 0;
        pad = 1'b1;
        step(); chk("ext_lat_n", mtime, 64'd0);
        step(); chk("ext_lat_n1", mtime, 64'd0);
        step(); chk("ext_lat_n2", mtime, 64'd1);
        chk("ext_lat_pulse", {63'd0, pulse}, 64'd1);
        step();
        pad = 1'b0; repeat (4) step();
        repeat (4) pad_pulse(4, 4);
        repeat (4) step();
        chk("ext_total", mtime, 64'd5);
        chk("ext_pulses", 64'(pcount), 64'd5);

        // Internal divider, ratio 3: 10 ticks in 40 cycles after the switch.
        ratio = 8'd3; sel = 1'b1;
        step();
        chk("switch_no_tick", {63'd0, pulse}, 64'd0);
        saved = mtime;
        repeat (40) step();
        chk("div3_40", mtime, saved + 64'd10);

        // Lower ratio 9 -> 2 while the period is at 6.
        ratio = 8'd9;
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (m_since == 6) hit = 1; else step();
        end
        chk("reach_cnt6", {63'd0, hit}, 64'd1);
        ratio = 8'd2;
        step(); chk("lower_ratio_tick", {63'd0, pulse}, 64'd1);
        saved = mtime;
        repeat (6) step();
        chk("ratio2_period", mtime, saved + 64'd2);

        // Load colliding with a tick (ratio 0 ticks every cycle).
        ratio = 8'd0; step();
        load = 1'b1; ldata = 64'h1234_0000_0000_0000;
        step(); load = 1'b0;
        chk("load_val", mtime, 64'h1234_0000_0000_0000);
        chk("load_pulse", {63'd0, pulse}, 64'd0);
        step(); chk("load_next", mtime, 64'h1234_0000_0000_0001);

        // Wrap, with set/clear collision.
        load = 1'b1; ldata = 64'hFFFF_FFFF_FFFF_FFFE;
        step(); load = 1'b0;
        step(); chk("wrap_ff", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        clr = 1'b1;
        step(); chk("wrap_zero", mtime, 64'd0);
        chk("wrap_set_wins", {63'd0, ovf}, 64'd1);
        clr = 1'b0;
        step(); chk("ovf_sticky", {63'd0, ovf}, 64'd1);
        clr = 1'b1;
        step(); chk("ovf_cleared", {63'd0, ovf}, 64'd0);
        clr = 1'b0;

        // Halt with external edges: frozen, no backlog.
        sel = 1'b0; step(); repeat (4) step();
        saved = mtime;
        halt = 1'b1;
        repeat (2) pad_pulse(4, 6);
        halt = 1'b0;
        repeat (6) step();
        chk("halt_frozen", mtime, saved);

        // Source switch with the pad held high.
        pad = 1'b1; repeat (6) step();
        ratio = 8'd3; sel = 1'b1;
        step(); chk("sw_hi_no_tick", {63'd0, pulse}, 64'd0);
        saved = mtime;
        repeat (3) step();
        chk("sw_div_restart", mtime, saved);
        step(); chk("sw_div_first", mtime, saved + 64'd1);
        sel = 1'b0;
        step(); chk("sw_back_no_tick", {63'd0, pulse}, 64'd0);
        step(); chk("sw_back_no_spur", {63'd0, pulse}, 64'd0);
        pad = 1'b0; repeat (4) step();

        // Random phase.
        hold = 4;
        for (int c = 0; c < 400; c++) begin
            if (hold == 0) begin pad = ~pad; hold = $urandom_range(6, 3); end
            hold--;
            if ($urandom_range(9, 0) == 0) halt = ~halt;
            if ($urandom_range(49, 0) == 0) sel = ~sel;
            if ($urandom_range(19, 0) == 0) ratio = W'($urandom_range(4, 0));
            load = ($urandom_range(29, 0) == 0);
            ldata = $urandom_range(1, 0) ? {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom_range(15, 12))}
                                         : {$urandom, $urandom};
            clr = ($urandom_range(7, 0) == 0);
            step();
        end
        load = 1'b0; halt = 1'b0; clr = 1'b0; pad = 1'b0;
        repeat (6) step();

        // Async reset mid-count at 37.
        sel = 1'b1; ratio = 8'd0; clr = 1'b1; step(); clr = 1'b0;
        load = 1'b1; ldata = 64'd36; step(); load = 1'b0;
        step(); chk("pre_rst_37", mtime, 64'd37);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mtime", mtime, 64'd0);
        chk("async_rst_pulse", {63'd0, pulse}, 64'd0);
        chk("async_rst_ovf", {63'd0, ovf}, 64'd0);
        model_reset();
        step(); step();
        rst_n = 1'b1;
        step(); chk("post_rst_switch", mtime, 64'd0);
        step(); chk("post_rst_first", mtime, 64'd1);
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sysio_mtime_gen.md
Name: sysio_mtime_gen

Overview:
- Generates the 64-bit machine timer value driven into the CLINT timer input (`sysio_clint_mtime`).
- Sits in the sysio stage directly upstream of the CLINT.
- Advances on a tick taken either from an asynchronous external system-counter pulse (synchronised and edge-detected) or from an internal programmable divider.
- Supports debug halt, software/pad load of the count, and a sticky wrap flag.

Parameters:
- SYNC_STAGES, 2, number of flops in the external tick synchroniser (legal range 2..3).
- DIV_W, 8, width of the internal divider ratio.

Ports:
- forever_cpuclk  in  1  free-running clock; the only clock of the block.
- cpurst_b  in  1  reset, asynchronous assert, active-low.
- pad_sysio_tick  in  1  asynchronous external tick; each rising edge requests one increment.
- tick_src_sel  in  1  0 = external tick, 1 = internal divider.
- div_ratio  in  DIV_W  internal tick period minus 1, in forever_cpuclk cycles.
- cnt_halt  in  1  freeze the count (debug halt).
- load_vld  in  1  one-cycle request to load the count.
- load_data  in  64  value to load.
- ovf_clr  in  1  clears the sticky wrap flag.
- sysio_clint_mtime  out  64  current timer value; registered.
- sysio_tick_pulse  out  1  high for the one cycle in which a newly incremented value is first presented.
- sysio_mtime_ovf  out  1  sticky flag: the count wrapped from all-ones to zero.

Behaviour:
- Reset (cpurst_b low, asynchronous):
  - sysio_clint_mtime = 0, sysio_tick_pulse = 0, sysio_mtime_ovf = 0.
  - All synchroniser flops, the edge-detect flop, the divider counter and the registered tick_src_sel are cleared.
- Reset released mid-operation: counting restarts from 0. No pending tick survives reset.
- External path:
  - pad_sysio_tick passes through SYNC_STAGES flops, then one edge-detect flop (prev).
  - ext_tick = sync_out & ~prev.
  - With SYNC_STAGES=2, a rising edge first sampled at edge N updates mtime at edge N+2. sysio_tick_pulse is high in the cycle after edge N+2.
  - The input pulse must stay high and low for at least SYNC_STAGES+1 cycles each; narrower pulses may be lost (documented limit, not detected).
- Internal path:
  - div_cnt counts up while the path is selected and not halted.
  - int_tick = (div_cnt >= div_ratio); on int_tick, div_cnt returns to 0, otherwise it increments.
  - div_ratio = 0 gives a tick every cycle; div_ratio = R gives a tick every R+1 cycles.
  - If div_ratio is lowered below the current div_cnt, the >= compare produces a tick immediately and the counter restarts from 0.
- Source select:
  - tick_src_sel is registered (sel_q).
  - In the cycle where tick_src_sel != sel_q, no tick is taken from either source, div_cnt is cleared and prev is loaded with sync_out.
  - An external level that is already high therefore does not produce a spurious tick.
- Tick qualification: tick = (sel_q ? int_tick : ext_tick) & ~cnt_halt & ~src_switch.
- Halt:
  - While cnt_halt = 1, mtime and div_cnt hold.
  - prev continues to track sync_out, so external edges arriving during halt are dropped, not queued.
  - Load is still honoured during halt.
- Update priority (per cycle):
  1. load_vld: mtime <= load_data. Any coincident tick is discarded, sysio_tick_pulse <= 0, and the wrap flag is unaffected by the load.
  2. tick: mtime <= mtime + 1 (64-bit, modulo 2^64) and sysio_tick_pulse <= 1.
  3. Otherwise mtime holds and sysio_tick_pulse <= 0.
- Wrap:
  - A tick with mtime = 64'hFFFF_FFFF_FFFF_FFFF gives mtime = 0 and sets sysio_mtime_ovf at the same edge.
  - ovf_clr clears the flag one edge later.
  - If set and clear occur in the same cycle, set wins.
- Output timing: all outputs come directly from flops; there is no combinational path from any input to any output.
- Load timing: a load takes effect at the next edge, so the loaded value is visible 1 cycle after load_vld.

Test Plan:
- Reset then external path: tick_src_sel=0, 5 clean pad_sysio_tick pulses (4 cycles high, 4 cycles low) -> mtime reaches 5; each increment lands 2 edges after first sampling; sysio_tick_pulse is high 5 times, one cycle each.
- Internal divider: tick_src_sel=1, div_ratio=3, run 40 cycles -> mtime increments every 4 cycles (10 total). Then change div_ratio from 9 to 2 while div_cnt=6 -> immediate tick next edge, then period 3.
- Load vs tick collision: assert load_vld with load_data=64'h1234_0000_0000_0000 in the same cycle as a tick -> mtime = 64'h1234_0000_0000_0000 exactly, sysio_tick_pulse=0; the following tick gives ...0001.
- Wrap: load 64'hFFFF_FFFF_FFFF_FFFE with div_ratio=0 -> values FFFF...FFFF, then 0, with sysio_mtime_ovf set on the wrap edge. Assert ovf_clr on that same cycle -> flag stays 1; a later ovf_clr -> 0.
- Halt and source switch: cnt_halt=1 for 20 cycles with external edges present -> mtime frozen and no backlog after release. Toggle tick_src_sel while pad_sysio_tick is held high -> no tick in the switch cycle and div_cnt restarts from 0.
- Asynchronous reset mid-count: drop cpurst_b at mtime=37, between clock edges -> all outputs are 0 immediately. After release, counting resumes from 0 with no residual tick.
